md_unit: RTL
============

# md_unit

Multiply/divide unit for the five-stage pipeline, in the E stage next to the ALU. Accepts one MULT/MULTU/DIV/DIVU (or MTHI/MTLO) per issue and runs the multi-cycle operation under a down-counter. It owns the HI/LO registers and drives the D-stage stall request while an MDU-dependent instruction cannot proceed.

## Interface
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU (and MADD/MSUB).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: E-stage issue qualifier for `md_op`; sampled on a rising edge.
- `md_op` input 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- `a` input 32: forwarded rs value.
- `b` input 32: forwarded rt value.
- `d_is_md` input 1: D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo/madd/msub.
- `hi` output 32: HI register; read by mfhi.
- `lo` output 32: LO register; read by mflo.
- `busy` output 1: an operation is in flight.
- `stall` output 1: freeze PC/IF-ID and bubble ID-EX this cycle.

## Operation
- States: IDLE (count==0) and BUSY (count!=0); `busy` = count!=0. 4-bit counter.
- IDLE, `start`=1, op 0..3 (or 6/7 with macro):
  - Latch `a`, `b` and op.
  - Load count with `MULT_CYCLES` or `DIV_CYCLES`.
- BUSY: count decrements each cycle. On the edge where count goes 1→0, HI/LO take the result; state returns to IDLE.
- MULT: signed 64-bit product; MULTU: unsigned. HI = [63:32], LO = [31:0].
- DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder (sign follows dividend).
  - Divisor 0: HI and LO unchanged, full latency still observed.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO with `start` in IDLE: HI or LO = `a` at that edge. No busy.
- `start` while BUSY (any op): ignored. The pipeline never issues this case, because `stall` holds the instruction in D.
- `stall` = `d_is_md` & (`start` | `busy`), combinational.
- Reset (`reset_n`=0 at an edge), including mid-operation:
  - HI = LO = 0, count = 0, `busy` = 0.
  - In-flight result is discarded.
  - `stall` then follows `start`/`d_is_md` only.

## Timing
- `start` at edge T: `busy` is high in cycles T+1 … T+N (N = latency). New HI/LO are visible from T+N+1.
- Back-to-back: a new `start` is accepted at edge T+N+1 at the earliest.
- MTHI/MTLO at edge T: visible from T+1.
- `hi`/`lo` are registered outputs. `stall` is combinational from `start`, `busy` and `d_is_md`.

## Configuration
- `MDU_MADD_EN` defined:
  - Op 6 MADD: {HI,LO} += signed a×b.
  - Op 7 MSUB: {HI,LO} −= signed a×b.
  - Both take `MULT_CYCLES`. The accumulation uses the HI/LO value at writeback time.
- `MDU_MADD_EN` undefined: ops 6/7 are no-ops. No busy; HI/LO unchanged.

## Structure
- Shared package `md_pkg` holds:
  - Op-code localparams `MD_MULT` … `MD_MSUB`.
  - Default `MULT_CYCLES`/`DIV_CYCLES`.
  - The decoder helper listing which instructions assert `d_is_md`.
- One sub-module, `md_arith`: combinational. Latched operands and op in → 64-bit {hi,lo} result plus `div_zero` flag out. `md_unit` keeps the counter, the state and the HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 at T:
  - `busy` high for T+1..T+5.
  - From T+6: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIVU a=100, b=7: from T+11, `lo`=14, `hi`=2. DIV a=−7, b=2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV with b=0 after MTHI 0x1234 / MTLO 0x5678:
  - `busy` lasts 10 cycles.
  - `hi`=0x1234 and `lo`=0x5678 afterwards.
- Hazard:
  - MULT issued and `d_is_md`=1 (mflo): `stall`=1 at T and through T+5, then 0 at T+6 with correct `lo`.
  - `d_is_md`=0 during busy: `stall`=0.
- Reset at T+3 of a DIV: from the next cycle `busy`=0, `hi`=`lo`=0, and no later writeback.
- With `MDU_MADD_EN`:
  - HI=0, LO=10, MADD 3×4: from T+6, `lo`=22.
  - MSUB 1×11 then gives `lo`=11.
  - Without the macro, op 6 leaves HI/LO unchanged and `busy`=0.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, default latencies and D-stage decoder for the multiply/divide unit
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MSUB  = 3'd7;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam int MD_CNT_W       = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Instructions that touch HI/LO and therefore must wait while the unit is busy.
    function automatic logic md_decode_is_md(input logic [5:0] opcode, input logic [5:0] funct);
        logic is_md;
        is_md = 1'b0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h10, 6'h11, 6'h12, 6'h13,
                6'h18, 6'h19, 6'h1A, 6'h1B: is_md = 1'b1;
                default:                    is_md = 1'b0;
            endcase
        end else if (opcode == 6'h1C) begin
            is_md = (funct == 6'h00) || (funct == 6'h04);
        end
        return is_md;
    endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational multiply/divide datapath; MDU_MADD_EN adds MADD/MSUB accumulation
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] acc,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_sdiv;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    assign is_sdiv = (op == MD_DIV);
    assign a_neg   = is_sdiv & a[31];
    assign b_neg   = is_sdiv & b[31];
    assign a_mag   = a_neg ? (~a + 32'd1) : a;
    assign b_mag   = b_neg ? (~b + 32'd1) : b;
    assign q_mag   = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag   = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

    assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

    always_comb begin
        result = acc;
        case (op)
            MD_MULT:         result = prod_s;
            MD_MULTU:        result = prod_u;
            MD_DIV, MD_DIVU: result = {rem, quot};
`ifdef MDU_MADD_EN
            MD_MADD:         result = acc + prod_s;
            MD_MSUB:         result = acc - prod_s;
`endif
            default:         result = acc;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit owning HI/LO; MDU_MADD_EN enables ops 6/7 (MADD/MSUB)
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    logic [MD_CNT_W-1:0] count_q, count_d;
    logic [2:0]          op_q, op_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [63:0]         result;
    logic                div_zero;
    md_state_e           state;

    md_arith u_arith (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .acc      ({hi_q, lo_q}),
        .result   (result),
        .div_zero (div_zero)
    );

    // The down-counter is the state register: nonzero means an operation is in flight.
    assign state = (count_q != '0) ? MD_BUSY : MD_IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                            count_d = MD_CNT_W'(MULT_CYCLES);
                        end
                        MD_DIV, MD_DIVU: begin
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                            count_d = MD_CNT_W'(DIV_CYCLES);
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
                        MD_MADD, MD_MSUB: begin
                            op_d    = md_op;
                            a_d     = a;
                            b_d     = b;
                            count_d = MD_CNT_W'(MULT_CYCLES);
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MD_BUSY: begin
                count_d = count_q - 1'b1;
                // Writeback on the last busy edge; a zero divisor keeps HI/LO intact.
                if ((count_q == MD_CNT_W'(1)) && !div_zero) begin
                    hi_d = result[63:32];
                    lo_d = result[31:0];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy  = (state == MD_BUSY);
        stall = d_is_md & (start | busy);
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
